// File: rtl/tdm_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tdm_demux                                                       |
// | Purpose  : Time-division 1-to-4 lane demultiplexer. Collects a repeating   |
// |            lane 0..3 sample stream (lane 0 marked by sof) into a shadow    |
// |            register and presents each complete frame as one registered     |
// |            4-lane word with a valid/ready handshake.                       |
// | Ports    : clk, rst_n          - clock, asynchronous active-low reset      |
// |            in_valid/in_ready   - input beat handshake                      |
// |            in_data, sof        - lane sample, start-of-frame qualifier     |
// |            sel                 - lane the next accepted beat will fill     |
// |            data_out            - lane i at [i*WIDTH +: WIDTH]              |
// |            out_valid/out_ready - output word handshake                     |
// |            frame_err           - one-cycle pulse on framing violation      |
// |            parity_err          - one-cycle pulse on parity mismatch        |
// | Options  : TDM_DEMUX_PARITY_EN - adds a fifth, even-parity beat per frame  |
// |            checked before the word is delivered; otherwise parity_err = 0. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tdm_demux #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               sof,
  output logic               in_ready,
  output logic [1:0]         sel,
  output logic [4*WIDTH-1:0] data_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_err,
  output logic               parity_err
);

  localparam logic [1:0] c_LANE_LAST = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
`ifdef TDM_DEMUX_PARITY_EN
    , S_PARITY = 2'd3
`endif
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sel;
  logic [4*WIDTH-1:0]   r_shadow;
  logic [4*WIDTH-1:0]   r_data_out;
  logic                 r_out_valid;
  logic                 r_frame_err;

  state_t               w_state_nxt;
  logic [1:0]           w_sel_nxt;
  logic [4*WIDTH-1:0]   w_shadow_nxt;
  logic [4*WIDTH-1:0]   w_data_out_nxt;
  logic                 w_out_valid_nxt;
  logic                 w_frame_err_nxt;
  logic                 w_in_ready;
  logic                 w_accept;
  logic [4*WIDTH-1:0]   w_shadow_lane;  // shadow with in_data placed at lane r_sel
  logic [4*WIDTH-1:0]   w_shadow_sof;   // shadow with in_data placed at lane 0

`ifdef TDM_DEMUX_PARITY_EN
  logic                 r_parity_err;
  logic                 w_parity_err_nxt;
`endif

  // Only HOLD can stall the input; it accepts exactly when the held word leaves.
  assign w_in_ready = (r_state == S_HOLD) ? out_ready : 1'b1;
  assign w_accept   = in_valid && w_in_ready;

  assign w_shadow_sof = {r_shadow[4*WIDTH-1:WIDTH], in_data};

  always_comb begin
    w_shadow_lane = r_shadow;
    for (int i = 0; i < 4; i++) begin
      if (r_sel == 2'(i)) begin
        w_shadow_lane[i*WIDTH +: WIDTH] = in_data;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_shadow_nxt     = r_shadow;
    w_data_out_nxt   = r_data_out;
    w_out_valid_nxt  = r_out_valid;
    w_frame_err_nxt  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    w_parity_err_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // Beats without sof are swallowed until a frame start arrives.
        if (w_accept && sof) begin
          w_shadow_nxt = w_shadow_sof;
          w_sel_nxt    = 2'd1;
          w_state_nxt  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_accept) begin
          if (sof) begin
            // Restart: partial frame abandoned, this beat is the new lane 0.
            w_frame_err_nxt = 1'b1;
            w_shadow_nxt    = w_shadow_sof;
            w_sel_nxt       = 2'd1;
          end else begin
            w_shadow_nxt = w_shadow_lane;
            if (r_sel == c_LANE_LAST) begin
              w_sel_nxt = 2'd0;
`ifdef TDM_DEMUX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt     = S_HOLD;
              w_data_out_nxt  = w_shadow_lane;
              w_out_valid_nxt = 1'b1;
`endif
            end else begin
              w_sel_nxt = r_sel + 2'd1;
            end
          end
        end
      end
`ifdef TDM_DEMUX_PARITY_EN
      S_PARITY: begin
        if (w_accept) begin
          if (sof) begin
            w_frame_err_nxt = 1'b1;
            w_shadow_nxt    = w_shadow_sof;
            w_sel_nxt       = 2'd1;
            w_state_nxt     = S_COLLECT;
          end else begin
            // Even parity: data bits plus parity bit must XOR to zero.
            w_parity_err_nxt = (^r_shadow) ^ in_data[0];
            w_data_out_nxt   = r_shadow;
            w_out_valid_nxt  = 1'b1;
            w_state_nxt      = S_HOLD;
          end
        end
      end
`endif
      S_HOLD: begin
        // out_valid is high throughout HOLD, so out_ready alone is the handshake.
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (in_valid && sof) begin
            w_shadow_nxt = w_shadow_sof;
            w_sel_nxt    = 2'd1;
            w_state_nxt  = S_COLLECT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= 2'd0;
      r_shadow    <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_shadow    <= w_shadow_nxt;
      r_data_out  <= w_data_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_parity_err_nxt;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign in_ready  = w_in_ready;
  assign sel       = r_sel;
  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tdm_demux                                                    |
// | Purpose  : Self-checking bench for tdm_demux: directed scenarios plus a    |
// |            randomized run against a frame-level queue model.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_tdm_demux;

  localparam int W = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           sof;
  logic           in_ready;
  logic [1:0]     sel;
  logic [4*W-1:0] data_out;
  logic           out_valid;
  logic           out_ready;
  logic           frame_err;
  logic           parity_err;

  int total = 0;
  int bad   = 0;

  tdm_demux #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .sof        (sof),
    .in_ready   (in_ready),
    .sel        (sel),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Frame-level model: samples of the frame being gathered, plus the held word.
  logic [W-1:0]   m_part[$];
  bit             m_coll;
  bit             m_hv;
  logic [4*W-1:0] m_word;
  bit             m_fe;
  bit             m_pe;
  bit             rdy_seen;
  bit             rdy_exp;

  task automatic model_reset();
    m_part.delete();
    m_coll = 0;
    m_hv   = 0;
    m_word = '0;
    m_fe   = 0;
    m_pe   = 0;
  endtask

  function automatic logic [1:0] exp_sel();
    return m_coll ? 2'(m_part.size() % 4) : 2'd0;
  endfunction

  task automatic deliver(input bit perr);
    for (int i = 0; i < 4; i++) m_word[i*W +: W] = m_part[i];
    m_pe   = perr;
    m_hv   = 1;
    m_coll = 0;
    m_part.delete();
  endtask

  // Drives one cycle of inputs, samples in_ready before the edge, advances the
  // model, and returns 1 time unit after the rising edge.
  task automatic step(input bit v, input bit s, input logic [W-1:0] d, input bit ordy);
    bit acc;
    logic [4*W-1:0] full;
    in_valid  = v;
    sof       = s;
    in_data   = d;
    out_ready = ordy;
    #1;
    rdy_seen = in_ready;
    rdy_exp  = m_hv ? ordy : 1'b1;
    acc      = v && rdy_exp;
    m_fe = 0;
    m_pe = 0;
    if (m_hv && ordy) m_hv = 0;
    if (acc) begin
      if (s) begin
        if (m_coll) m_fe = 1;
        m_part.delete();
        m_part.push_back(d);
        m_coll = 1;
      end else if (m_coll) begin
        if (m_part.size() < 4) begin
          m_part.push_back(d);
`ifndef TDM_DEMUX_PARITY_EN
          if (m_part.size() == 4) deliver(1'b0);
`endif
        end else begin
          full = '0;
          for (int i = 0; i < 4; i++) full[i*W +: W] = m_part[i];
          deliver(((^full) ^ d[0]) == 1'b1);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Sends lanes first..3 of word (sof on lane 0), then the parity beat when built.
  task automatic send_lanes(input logic [4*W-1:0] word, input int first, input bit ordy,
                            input bit par_flip);
    logic [W-1:0] pb;
    for (int i = first; i < 4; i++) step(1'b1, (i == 0), word[i*W +: W], ordy);
    pb    = '0;
    pb[0] = (^word) ^ par_flip;
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, pb, ordy);
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; sof = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data_out got=%h want=0", data_out); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", sel); end
    total++; if (frame_err !== 1'b0 || parity_err !== 1'b0) begin bad++; $display("FAIL reset_errs got=%b%b want=00", frame_err, parity_err); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    // Reset while holding a word.
    send_lanes(4'b1001, 0, 1'b0, 1'b0);
    total++; if (data_out !== 4'b1001) begin bad++; $display("FAIL hold_before_rst got=%b want=1001", data_out); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || data_out !== '0) begin bad++; $display("FAIL rst_mid_hold got=%b/%b want=0/0000", out_valid, data_out); end
    #1 rst_n = 1'b1;
    model_reset();
    // Reset mid-frame.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    total++; if (sel !== 2'd2) begin bad++; $display("FAIL pre_rst_sel got=%0d want=2", sel); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (sel !== 2'd0 || frame_err !== 1'b0) begin bad++; $display("FAIL rst_mid_frame got=%0d/%b want=0/0", sel, frame_err); end
    #1 rst_n = 1'b1;
    model_reset();
    send_lanes(4'b1100, 0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1 || data_out !== 4'b1100) begin bad++; $display("FAIL post_rst_frame got=%b/%b want=1/1100", out_valid, data_out); end
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_basic();
    logic [3:0] oh;
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      send_lanes(oh, 0, 1'b1, 1'b0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_%0d got=%b want=1", k, out_valid); end
      total++; if (data_out !== oh) begin bad++; $display("FAIL basic_data_%0d got=%b want=%b", k, data_out, oh); end
      step(1'b0, 1'b0, '0, 1'b1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop_%0d got=%b want=0", k, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    send_lanes(4'b1010, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, W'($urandom), 1'b0);
      total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL bp_in_ready_%0d got=%b want=0", k, rdy_seen); end
      total++; if (out_valid !== 1'b1 || data_out !== 4'b1010) begin bad++; $display("FAIL bp_hold_%0d got=%b/%b want=1/1010", k, out_valid, data_out); end
    end
    // Handshake coincident with the next frame's sof beat (lane 0 of 0101 = 1).
    step(1'b1, 1'b1, 1'b1, 1'b1);
    total++; if (rdy_seen !== 1'b1 || sel !== 2'd1) begin bad++; $display("FAIL bp_release got=%b/%0d want=1/1", rdy_seen, sel); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    send_lanes(4'b0101, 1, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1 || data_out !== 4'b0101) begin bad++; $display("FAIL bp_next_frame got=%b/%b want=1/0101", out_valid, data_out); end
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_framing();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_err_early got=%b want=0", frame_err); end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    total++; if (frame_err !== 1'b1 || sel !== 2'd1) begin bad++; $display("FAIL frame_err_pulse got=%b/%0d want=1/1", frame_err, sel); end
    send_lanes(4'b0110, 1, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1 || data_out !== 4'b0110) begin bad++; $display("FAIL frame_recover got=%b/%b want=1/0110", out_valid, data_out); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_err_single got=%b want=0", frame_err); end
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_junk();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      total++; if (out_valid !== 1'b0 || sel !== 2'd0) begin bad++; $display("FAIL junk_%0d got=%b/%0d want=0/0", k, out_valid, sel); end
    end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    send_lanes(4'b0111, 0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1 || parity_err !== 1'b0) begin bad++; $display("FAIL parity_ok got=%b/%b want=1/0", out_valid, parity_err); end
    step(1'b0, 1'b0, '0, 1'b1);
    send_lanes(4'b0111, 0, 1'b1, 1'b1);
    total++; if (out_valid !== 1'b1 || parity_err !== 1'b1) begin bad++; $display("FAIL parity_bad got=%b/%b want=1/1", out_valid, parity_err); end
    total++; if (data_out !== 4'b0111) begin bad++; $display("FAIL parity_data got=%b want=0111", data_out); end
    step(1'b0, 1'b0, '0, 1'b1);
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL parity_pulse got=%b want=0", parity_err); end
  endtask
`endif

  task automatic test_random();
    bit v, s, o;
    logic [W-1:0] d;
    for (int n = 0; n < 2000; n++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 5) == 0);
      o = ($urandom_range(0, 2) != 0);
      d = W'($urandom);
      step(v, s, d, o);
      total++; if (rdy_seen !== rdy_exp) begin bad++; $display("FAIL rnd_in_ready n=%0d got=%b want=%b", n, rdy_seen, rdy_exp); end
      total++; if (out_valid !== m_hv) begin bad++; $display("FAIL rnd_out_valid n=%0d got=%b want=%b", n, out_valid, m_hv); end
      total++; if (data_out !== m_word) begin bad++; $display("FAIL rnd_data_out n=%0d got=%h want=%h", n, data_out, m_word); end
      total++; if (sel !== exp_sel()) begin bad++; $display("FAIL rnd_sel n=%0d got=%0d want=%0d", n, sel, exp_sel()); end
      total++; if (frame_err !== m_fe) begin bad++; $display("FAIL rnd_frame_err n=%0d got=%b want=%b", n, frame_err, m_fe); end
      total++; if (parity_err !== m_pe) begin bad++; $display("FAIL rnd_parity_err n=%0d got=%b want=%b", n, parity_err, m_pe); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_framing();
    test_junk();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdm_demux.md
# tdm_demux

Time-division 1-to-4 demultiplexer: the receive-side counterpart of the 4:1 lane multiplexer. Takes a stream of lane samples (lane 0, 1, 2, 3, repeating), steers each one into its lane slot, and presents the reassembled four-lane word on a registered output with a valid/ready handshake. Sits between the serial link and the parallel consumer logic.

## Interface
- `WIDTH`, default 1: bits per lane sample.
- `clk` in, 1: rising-edge clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `in_valid` in, 1: an input beat is offered.
- `in_data` in, WIDTH: lane sample.
- `sof` in, 1: start of frame; qualifies a beat as lane 0.
- `in_ready` out, 1: a beat is accepted when `in_valid && in_ready`.
- `sel` out, 2: lane index the next accepted beat will fill.
- `data_out` out, 4*WIDTH: lane i sits at `[i*WIDTH +: WIDTH]`.
- `out_valid` out, 1: `data_out` holds a complete frame.
- `out_ready` in, 1: consumer takes the word when `out_valid && out_ready`.
- `frame_err` out, 1: one-cycle pulse on a framing violation.
- `parity_err` out, 1: only with `TDM_DEMUX_PARITY_EN`; otherwise tied 0.

## Operation
- **States:** IDLE, COLLECT, PARITY (macro builds only), HOLD.
- **IDLE:**
  - `in_ready` = 1.
  - Beats without `sof` are accepted and discarded.
  - A `sof` beat is written to shadow lane 0; then `sel` = 1 and the state goes to COLLECT.
- **COLLECT:**
  - `in_ready` = 1.
  - Each accepted beat is written to shadow lane `sel`, and `sel` increments.
  - On the lane-3 beat, the state goes to PARITY if the macro is defined, otherwise to HOLD.
- **Entering HOLD:**
  - The shadow register is copied to `data_out`.
  - `out_valid` = 1 and `sel` = 0.
- **HOLD:**
  - `in_ready` = `out_ready`.
  - `data_out` and `out_valid` stay stable until the handshake completes.
  - On handshake without a simultaneous input beat: `out_valid` = 0, next state IDLE.
  - On handshake with a simultaneous `sof` beat: that beat becomes lane 0 of the next frame, next state COLLECT, `sel` = 1.
  - On handshake with a simultaneous non-`sof` beat: the beat is discarded, next state IDLE.
- **`sof` while in COLLECT (any `sel`, including 1–3):**
  - The partial frame is dropped and `frame_err` pulses.
  - The beat becomes the new lane 0, `sel` = 1, and the state stays COLLECT.
- **`data_out` update rule:** `data_out` changes only on entry to HOLD. Shadow lanes not yet written in the current frame keep stale contents, and those stale contents are never exposed.
- **`sel` counter:** 2-bit, wraps 3→0 only through HOLD/PARITY. It is never driven by `sof` to any value other than 1.

## Timing
- **Reset values** (asynchronous, on `rst_n` low):
  - State IDLE.
  - `sel` = 0, `data_out` = 0, shadow = 0.
  - `out_valid` = 0, `frame_err` = 0, `parity_err` = 0.
  - `in_ready` = 1 once `rst_n` is high.
- **Reset mid-frame or mid-HOLD:** all contents are lost, with no error pulse.
- **Latency:** `out_valid` rises on the clock edge that accepts the last beat of the frame (lane 3, or the parity beat). `data_out` is visible the next cycle.
- **Throughput:** one frame per 4 cycles with `out_ready` held high (5 cycles with parity). HOLD adds no bubble when `sof` is offered on the handshake cycle.
- **`in_ready`:** combinational from state and `out_ready` only; it never depends on `in_valid`.
- **`frame_err` / `parity_err`:** registered, high for exactly one cycle after the offending beat is accepted.

## Configuration
- **`TDM_DEMUX_PARITY_EN` defined:**
  - Each frame carries a fifth beat; its `in_data[0]` is an even-parity bit over all 4*WIDTH data bits, and the other bits are ignored.
  - Acceptance of that beat (in the PARITY state) moves to HOLD.
  - On mismatch, `parity_err` pulses in the same cycle `out_valid` rises; the word is still delivered.
  - `sof` on the parity beat is treated as a framing violation: `frame_err` pulses, the frame is dropped, and the beat starts a new frame.
- **Undefined:** the PARITY state and parity logic are absent, frames are 4 beats, and `parity_err` is 0.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame → all outputs 0, `in_ready`=1 after release, and the next `sof` starts a clean frame.
- **Basic frame:** WIDTH=1, `out_ready`=1, beats 1,0,0,0 with `sof` on the first → `data_out`=4'b0001, `out_valid` for 1 cycle. Repeat with one-hot 4'b0010, 4'b0100, 4'b1000.
- **Backpressure:** frame 4'b1010 with `out_ready`=0 for 5 cycles → `data_out` held at 4'b1010, `in_ready`=0. Raise `out_ready` together with a `sof` beat → the next frame completes with no bubble.
- **Framing recovery:** `sof`, two beats, then `sof` again → `frame_err` pulse, partial frame dropped; the following complete frame 4'b0110 is delivered intact.
- **Junk in IDLE:** three beats without `sof` → no `out_valid`, `sel` stays 0.
- **Parity (macro on):** frame 4'b0111 with parity bit 1 → no error; same frame with parity bit 0 → `parity_err` pulse coincident with `out_valid`, `data_out`=4'b0111.
